// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in, computes duty with an R+1 cycle restoring divider.
// Optional input deglitch filter enabled by defining PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture #(
   parameter int R  = 8,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pwm_in,
   input  logic [CW-1:0] timeout,
   output logic [CW-1:0] period,
   output logic [CW-1:0] high_time,
   output logic [R:0]    duty,
   output logic          valid,
   output logic          busy,
   output logic          overrun,
   output logic          stuck_hi,
   output logic          stuck_lo
);

   typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

   localparam int            DCW      = (R > 0) ? $clog2(R + 1) : 1;
   localparam logic [DCW-1:0] DIV_LAST = DCW'(R);
   localparam logic [CW-1:0]  CNT_MAX  = '1;
   localparam logic [R:0]     FULL     = {1'b1, {R{1'b0}}};

   state_t         state, state_n;
   logic           sync1, sync2, pwm_s, pwm_d, rise;
   logic [CW-1:0]  per_cnt, hi_cnt;
   logic [CW-1:0]  period_q, high_q;
   logic [CW:0]    rem, rem_nxt;
   logic [R-1:0]   quot;
   logic [DCW-1:0] div_cnt;
   logic           q_bit, div_last, per_hit, tmo_fire, tmo_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
      end
   end

`ifdef PWM_CAPTURE_DEGLITCH_EN
   logic [1:0] hist;
   logic       pwm_f;

   // pwm_s follows only once the synchronised input has agreed for 3 cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist  <= 2'b00;
         pwm_f <= 1'b0;
      end else begin
         hist  <= {hist[0], sync2};
         pwm_f <= pwm_s;
      end
   end

   always_comb begin
      pwm_s = pwm_f;
      if (sync2 & hist[0] & hist[1])
         pwm_s = 1'b1;
      else if (~sync2 & ~hist[0] & ~hist[1])
         pwm_s = 1'b0;
   end
`else
   assign pwm_s = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_d <= 1'b0;
      else        pwm_d <= pwm_s;
   end

   assign rise = pwm_s & ~pwm_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= CW'(1);
         hi_cnt  <= CW'(1);
      end else begin
         if (per_cnt != CNT_MAX)          per_cnt <= per_cnt + CW'(1);
         if (pwm_s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CW'(1);
      end
   end

   assign per_hit  = (timeout != '0) && (per_cnt == timeout);
   // A match seen while dividing is remembered and fires once back in MEASURE
   assign tmo_fire = (state != DIVIDE) && !rise && (per_hit || tmo_pend) && !stuck_hi && !stuck_lo;
   assign div_last = (state == DIVIDE) && (div_cnt == DIV_LAST);
   assign q_bit    = (rem >= {1'b0, period_q});
   assign rem_nxt  = q_bit ? (rem - {1'b0, period_q}) : rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (rise) state_n = MEASURE;
         MEASURE: if (rise) state_n = DIVIDE;
                  else if (tmo_fire) state_n = IDLE;
         DIVIDE:  if (div_last) state_n = MEASURE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == DIVIDE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period    <= '0;
         high_time <= '0;
         duty      <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         stuck_hi  <= 1'b0;
         stuck_lo  <= 1'b0;
         tmo_pend  <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         rem       <= '0;
         quot      <= '0;
         div_cnt   <= '0;
      end else begin
         valid   <= 1'b0;
         overrun <= 1'b0;
         if (rise) begin
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
            tmo_pend <= 1'b0;
         end else if (state == DIVIDE && per_hit) begin
            tmo_pend <= 1'b1;
         end

         if (state == MEASURE && rise) begin
            period_q <= per_cnt;
            high_q   <= hi_cnt;
            rem      <= {1'b0, hi_cnt};
            quot     <= '0;
            div_cnt  <= '0;
         end

         if (state == DIVIDE) begin
            rem     <= rem_nxt << 1;
            quot    <= R'({quot, q_bit});
            div_cnt <= div_cnt + DCW'(1);
            if (rise) overrun <= 1'b1;
            if (div_last) begin
               period    <= period_q;
               high_time <= high_q;
               duty      <= (period_q == '0) ? '0 : {quot, q_bit};
               valid     <= 1'b1;
            end
         end

         if (tmo_fire) begin
            period    <= '0;
            high_time <= '0;
            duty      <= pwm_s ? FULL : '0;
            stuck_hi  <= pwm_s;
            stuck_lo  <= ~pwm_s;
            valid     <= 1'b1;
            tmo_pend  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expectations queued as rises are driven, checked on each valid.
module tb_pwm_capture;
   localparam int R  = 8;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pwm_in = 1'b0;
   logic [CW-1:0] timeout = '0;
   logic [CW-1:0] period, high_time;
   logic [R:0]    duty;
   logic          valid, busy, overrun, stuck_hi, stuck_lo;

   pwm_capture #(.R(R), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .timeout(timeout),
      .period(period), .high_time(high_time), .duty(duty), .valid(valid),
      .busy(busy), .overrun(overrun), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] per;
      logic [CW-1:0] hi;
      logic [R:0]    duty;
      logic          shi;
      logic          slo;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   total = 0, bad = 0;
   int   valid_cnt = 0, ovr_cnt = 0, busy_cnt = 0;

   function automatic exp_t mk(input int p, input int h, input int d, input logic sh, input logic sl);
      exp_t x;
      x.per  = CW'(p);
      x.hi   = CW'(h);
      x.duty = (R+1)'(d);
      x.shi  = sh;
      x.slo  = sl;
      return x;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy)    busy_cnt++;
         if (overrun) ovr_cnt++;
         if (valid) begin
            valid_cnt++;
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid: period=%0d high=%0d duty=%0d at %0t", period, high_time, duty, $time);
            end else begin
               e = sbq.pop_front();
               if ({period, high_time, duty, stuck_hi, stuck_lo} !== {e.per, e.hi, e.duty, e.shi, e.slo}) begin
                  bad++;
                  $display("FAIL scoreboard: got per=%0d hi=%0d duty=%0d shi=%0b slo=%0b, want per=%0d hi=%0d duty=%0d shi=%0b slo=%0b",
                           period, high_time, duty, stuck_hi, stuck_lo, e.per, e.hi, e.duty, e.shi, e.slo);
               end
            end
         end
      end
   end

   task automatic do_reset(input logic [CW-1:0] tmo);
      @(negedge clk);
      rst_n   = 1'b0;
      pwm_in  = 1'b0;
      timeout = tmo;
      sbq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive_period(input int h, input int l);
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({period, high_time, duty, valid, busy, overrun, stuck_hi, stuck_lo} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: per=%0d hi=%0d duty=%0d v=%0b b=%0b o=%0b sh=%0b sl=%0b, want all 0",
                  period, high_time, duty, valid, busy, overrun, stuck_hi, stuck_lo);
      end
      do_reset('0);
   endtask

   task automatic test_steady();
      int v0;
      do_reset('0);
      v0 = valid_cnt;
      drive_period(64, 192);
      for (int k = 0; k < 3; k++) begin
         sbq.push_back(mk(256, 64, 64, 1'b0, 1'b0));
         drive_period(64, 192);
      end
      repeat (20) @(negedge clk);
      total++;
      if (valid_cnt - v0 != 3) begin
         bad++;
         $display("FAIL steady_valid_count: got %0d want 3", valid_cnt - v0);
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL steady_pending: got %0d want 0", sbq.size());
      end
   endtask

   task automatic test_latency();
      int v0, b0, lat;
      do_reset('0);
      v0 = valid_cnt;
      drive_period(100, 200);
      sbq.push_back(mk(300, 100, 85, 1'b0, 1'b0));
      b0  = busy_cnt;
      lat = 0;
      pwm_in = 1'b1;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk);
         if (valid && lat == 0) lat = j;
      end
      pwm_in = 1'b0;
      total++;
      if (lat != 12) begin
         bad++;
         $display("FAIL valid_latency: got %0d want 12 negedges after drive", lat);
      end
      total++;
      if (busy_cnt - b0 != R + 1) begin
         bad++;
         $display("FAIL busy_cycles: got %0d want %0d", busy_cnt - b0, R + 1);
      end
      repeat (200) @(negedge clk);
      sbq.push_back(mk(300, 100, 85, 1'b0, 1'b0));
      drive_period(100, 20);
      total++;
      if (valid_cnt - v0 != 2 || sbq.size() != 0) begin
         bad++;
         $display("FAIL latency_valid_count: got %0d pending %0d want 2 pending 0", valid_cnt - v0, sbq.size());
      end
   endtask

   task automatic test_stuck_hi();
      int v0;
      do_reset(CW'(1000));
      v0 = valid_cnt;
      drive_period(64, 192);
      sbq.push_back(mk(256, 64, 64, 1'b0, 1'b0));
      sbq.push_back(mk(0, 0, 256, 1'b1, 1'b0));
      pwm_in = 1'b1;
      repeat (1100) @(negedge clk);
      total++;
      if (stuck_hi !== 1'b1 || stuck_lo !== 1'b0) begin
         bad++;
         $display("FAIL stuck_hi_flag: got sh=%0b sl=%0b want sh=1 sl=0", stuck_hi, stuck_lo);
      end
      total++;
      if (valid_cnt - v0 != 2 || sbq.size() != 0) begin
         bad++;
         $display("FAIL stuck_hi_valids: got %0d pending %0d want 2 pending 0", valid_cnt - v0, sbq.size());
      end
      pwm_in = 1'b0;
      repeat (10) @(negedge clk);
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (stuck_hi !== 1'b0 || valid_cnt - v0 != 2) begin
         bad++;
         $display("FAIL stuck_hi_clear: got sh=%0b valids=%0d want sh=0 valids=2", stuck_hi, valid_cnt - v0);
      end
   endtask

   task automatic test_stuck_lo();
      int v0, v1;
      do_reset(CW'(500));
      v0 = valid_cnt;
      sbq.push_back(mk(0, 0, 0, 1'b0, 1'b1));
      repeat (1200) @(negedge clk);
      total++;
      if (stuck_lo !== 1'b1 || duty !== '0 || valid_cnt - v0 != 1) begin
         bad++;
         $display("FAIL stuck_lo: got sl=%0b duty=%0d valids=%0d want sl=1 duty=0 valids=1", stuck_lo, duty, valid_cnt - v0);
      end
      v1 = valid_cnt;
      drive_period(64, 192);
      total++;
      if (stuck_lo !== 1'b0 || valid_cnt != v1) begin
         bad++;
         $display("FAIL stuck_lo_recover: got sl=%0b valids=%0d want sl=0 valids=0", stuck_lo, valid_cnt - v1);
      end
      sbq.push_back(mk(256, 64, 64, 1'b0, 1'b0));
      pwm_in = 1'b1;
      repeat (20) @(negedge clk);
      pwm_in = 1'b0;
      total++;
      if (valid_cnt - v1 != 1 || sbq.size() != 0) begin
         bad++;
         $display("FAIL stuck_lo_measure: got %0d pending %0d want 1 pending 0", valid_cnt - v1, sbq.size());
      end
   endtask

   task automatic test_overrun();
      int v0, o0;
      do_reset('0);
      v0 = valid_cnt;
      o0 = ovr_cnt;
      for (int k = 1; k <= 9; k++) begin
         if (k % 2 == 0) sbq.push_back(mk(5, 2, 102, 1'b0, 1'b0));
         drive_period(2, 3);
      end
      repeat (30) @(negedge clk);
      total++;
      if (ovr_cnt - o0 != 4) begin
         bad++;
         $display("FAIL overrun_count: got %0d want 4", ovr_cnt - o0);
      end
      total++;
      if (valid_cnt - v0 != 4 || sbq.size() != 0) begin
         bad++;
         $display("FAIL overrun_valids: got %0d pending %0d want 4 pending 0", valid_cnt - v0, sbq.size());
      end
   endtask

   task automatic test_reset_mid_divide();
      int v0;
      do_reset('0);
      drive_period(64, 192);
      sbq.push_back(mk(256, 64, 64, 1'b0, 1'b0));
      drive_period(64, 192);
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (busy !== 1'b1 || period !== CW'(256)) begin
         bad++;
         $display("FAIL pre_reset_state: got busy=%0b per=%0d want busy=1 per=256", busy, period);
      end
      #2;
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      #1;
      total++;
      if ({period, high_time, duty, valid, busy, overrun, stuck_hi, stuck_lo} !== '0) begin
         bad++;
         $display("FAIL mid_divide_reset: per=%0d hi=%0d duty=%0d v=%0b b=%0b, want all 0", period, high_time, duty, valid, busy);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      v0 = valid_cnt;
      drive_period(64, 192);
      total++;
      if (valid_cnt != v0) begin
         bad++;
         $display("FAIL post_reset_first_rise: got %0d valids want 0", valid_cnt - v0);
      end
      sbq.push_back(mk(256, 64, 64, 1'b0, 1'b0));
      drive_period(64, 20);
      total++;
      if (valid_cnt - v0 != 1 || sbq.size() != 0) begin
         bad++;
         $display("FAIL post_reset_measure: got %0d pending %0d want 1 pending 0", valid_cnt - v0, sbq.size());
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_latency();
      test_stuck_hi();
      test_stuck_lo();
      test_overrun();
      test_reset_mid_divide();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
